// File: rtl/wbslave.sv
// Wishbone classic-cycle slave: word-addressed register file with programmable
// wait states, ERR on out-of-range indices, and a doorbell word driving INTR_O.
module wbslave #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int SW          = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  input  logic          WE_I,
  input  logic [SW-1:0] SEL_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          INTR_O
);

  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;
  localparam int MW  = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_ack;
  logic            r_err;
  logic            r_intr;
  logic [DW-1:0]   r_dat;
  logic [DW-1:0]   r_door;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_req;
  logic            w_exec;
  logic            w_load;
  logic [IW-1:0]   w_idx;
  logic            w_inrange;
  logic            w_isdoor;
  logic [DW-1:0]   w_rdata;
  logic [DW-1:0]   w_door_nxt;
  logic            w_unused;

  assign w_req     = CYC_I & STB_I;
  assign w_idx     = ADR_I[AW-1:LSB];
  assign w_inrange = 32'(w_idx) < DEPTH;
  assign w_isdoor  = 32'(w_idx) == DEPTH - 1;
  assign w_rdata   = w_isdoor ? r_door : r_mem[w_idx[MW-1:0]];
  assign w_unused  = ^ADR_I[LSB-1:0];

  always_ff @(posedge CLK_I) begin
    if (!RST_I) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // w_exec marks the edge that enters RESP; the transaction commits there.
  always_comb begin
    w_next = r_state;
    w_exec = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_load = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next = S_RESP;
            w_exec = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = S_RESP;
          w_exec = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_door_nxt = r_door;
    if (w_exec && WE_I && w_isdoor) begin
      for (int i = 0; i < SW; i++)
        if (SEL_I[i]) w_door_nxt[8*i +: 8] = DAT_I[8*i +: 8];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_cnt  <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_dat  <= '0;
      r_door <= '0;
      r_intr <= 1'b0;
    end else begin
      if (w_load)                r_cnt <= 4'(WAIT_STATES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
      r_ack  <= w_exec && w_inrange;
      r_err  <= w_exec && !w_inrange;
      r_dat  <= (w_exec && w_inrange && !WE_I) ? w_rdata : '0;
      r_door <= w_door_nxt;
      r_intr <= |w_door_nxt;
    end
  end

  // Scratch RAM has no reset; the doorbell word lives in r_door instead.
  always_ff @(posedge CLK_I) begin
    if (RST_I && w_exec && WE_I && w_inrange && !w_isdoor) begin
      for (int i = 0; i < SW; i++)
        if (SEL_I[i]) r_mem[w_idx[MW-1:0]][8*i +: 8] <= DAT_I[8*i +: 8];
    end
  end

  assign ACK_O  = r_ack;
  assign ERR_O  = r_err;
  assign DAT_O  = r_dat;
  assign INTR_O = r_intr;

endmodule

// File: tb/tb_wbslave.sv
// Directed bench for wbslave: one instance with no wait states, one with three,
// expected responses queued at drive time and checked when ACK/ERR appears.
module tb_wbslave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adr = '0;
  logic [31:0] dati = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic [1:0]  cyc = '0;
  logic [1:0]  ack, err, intr;
  logic [31:0] dato0, dato1;

  always #5 clk = ~clk;

  wbslave #(.WAIT_STATES(0)) u0 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_I(adr), .DAT_I(dati), .DAT_O(dato0),
    .WE_I(we), .SEL_I(sel), .STB_I(stb), .CYC_I(cyc[0]),
    .ACK_O(ack[0]), .ERR_O(err[0]), .INTR_O(intr[0]));

  wbslave #(.WAIT_STATES(3)) u1 (
    .CLK_I(clk), .RST_I(rst_n), .ADR_I(adr), .DAT_I(dati), .DAT_O(dato1),
    .WE_I(we), .SEL_I(sel), .STB_I(stb), .CYC_I(cyc[1]),
    .ACK_O(ack[1]), .ERR_O(err[1]), .INTR_O(intr[1]));

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        intr;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] mem_m [2][16];
  logic [31:0] door_m [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dout(input int k);
    return (k == 1) ? dato1 : dato0;
  endfunction

  task automatic quiet(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "/ack"}, 32'(ack), 32'd0);
      chk({tag, "/err"}, 32'(err), 32'd0);
    end
  endtask

  task automatic txn(input int k, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] s, input string tag);
    int    ws  = (k == 1) ? 3 : 0;
    int    idx = int'(a[7:2]);
    bit    got = 1'b0;
    resp_t e;
    resp_t r;
    e.ack = (idx < 16);
    e.err = !(idx < 16);
    e.dat = '0;
    if (idx < 16) begin
      if (w) begin
        if (idx == 15) door_m[k] = merge(door_m[k], d, s);
        else           mem_m[k][idx] = merge(mem_m[k][idx], d, s);
      end else begin
        e.dat = (idx == 15) ? door_m[k] : mem_m[k][idx];
      end
    end
    e.intr = |door_m[k];
    sb.push_back(e);
    @(negedge clk);
    adr = a; dati = d; we = w; sel = s; stb = 1'b1; cyc[k] = 1'b1;
    for (int c = 1; c <= ws + 4 && !got; c++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        got = 1'b1;
        r = sb.pop_front();
        chk({tag, "/latency"}, 32'(c), 32'(ws + 1));
        chk({tag, "/ack"}, 32'(ack[k]), 32'(r.ack));
        chk({tag, "/err"}, 32'(err[k]), 32'(r.err));
        chk({tag, "/dat"}, dout(k), r.dat);
        chk({tag, "/intr"}, 32'(intr[k]), 32'(r.intr));
        stb = 1'b0; cyc[k] = 1'b0;
      end
    end
    chk({tag, "/responded"}, 32'(got), 32'd1);
    if (!got) begin
      void'(sb.pop_front());
      stb = 1'b0; cyc[k] = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, "/dat_after"}, dout(k), 32'd0);
      chk({tag, "/ack_after"}, 32'(ack[k] | err[k]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      door_m[k] = '0;
      for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
    end

    // Reset held two cycles with a live write request on both slaves
    rst_n = 1'b0; stb = 1'b1; cyc = 2'b11;
    adr = 8'h04; dati = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF;
    repeat (2) begin
      @(negedge clk);
      chk("rst/ack", 32'(ack), 32'd0);
      chk("rst/err", 32'(err), 32'd0);
      chk("rst/intr", 32'(intr), 32'd0);
      chk("rst/dat0", dato0, 32'd0);
      chk("rst/dat1", dato1, 32'd0);
    end
    rst_n = 1'b1; stb = 1'b0; cyc = '0;
    quiet(3, "post_rst");

    txn(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, "wr04");
    txn(0, 1'b0, 8'h04, 32'h0, 4'hF, "rd04");
    txn(0, 1'b1, 8'h04, 32'h0000_AA00, 4'h2, "wr_lane1");
    txn(0, 1'b0, 8'h04, 32'h0, 4'h0, "rd_lane1");
    txn(0, 1'b1, 8'h04, 32'h1234_5678, 4'h0, "wr_sel0");
    txn(0, 1'b0, 8'h07, 32'h0, 4'hF, "rd_misalign");

    for (int i = 0; i < 15; i++)
      if (i != 1) txn(0, 1'b1, 8'(i * 4), 32'hA5A5_A5A5 ^ (32'(i) * 32'h0101_0101), 4'hF, "fill");
    txn(0, 1'b0, 8'h40, 32'h0, 4'hF, "rd_oor");
    txn(0, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, "wr_oor");
    txn(0, 1'b0, 8'hFC, 32'h0, 4'hF, "rd_oor_top");
    for (int i = 0; i < 16; i++) txn(0, 1'b0, 8'(i * 4), 32'h0, 4'hF, "scan");

    txn(0, 1'b1, 8'h3C, 32'h0000_0001, 4'hF, "db_set");
    txn(0, 1'b0, 8'h3C, 32'h0, 4'hF, "db_rd");
    txn(0, 1'b1, 8'h3C, 32'h0000_0000, 4'hF, "db_clr");
    txn(0, 1'b1, 8'h3C, 32'h0000_0080, 4'h1, "db_set2");

    txn(1, 1'b1, 8'h08, 32'h1234_5678, 4'hF, "ws3_wr");
    txn(1, 1'b0, 8'h08, 32'h0, 4'hF, "ws3_rd");
    txn(1, 1'b1, 8'h44, 32'h0, 4'hF, "ws3_oor");

    // Strobe dropped after two cycles in the wait phase: nothing happens
    @(negedge clk);
    adr = 8'h08; dati = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
    @(negedge clk);
    chk("abort/early", 32'(ack[1] | err[1]), 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc[1] = 1'b0;
    quiet(6, "abort");
    txn(1, 1'b0, 8'h08, 32'h0, 4'hF, "abort_rd");

    // Reset lands in the cycle before RESP: no response, no write
    @(negedge clk);
    adr = 8'h08; dati = 32'hCAFE_F00D; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_resp/ack", 32'(ack), 32'd0);
    chk("rst_resp/err", 32'(err), 32'd0);
    chk("rst_resp/intr", 32'(intr), 32'd0);
    rst_n = 1'b1; stb = 1'b0; cyc = '0;
    door_m[0] = '0; door_m[1] = '0;
    quiet(4, "rst_resp_after");
    txn(1, 1'b0, 8'h08, 32'h0, 4'hF, "rst_resp_rd");
    txn(0, 1'b0, 8'h3C, 32'h0, 4'hF, "db_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
